// File: rtl/inst_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_buffer
// Brief    : Instruction fetch front end for a split request/response
//            instruction bus. It issues sequential fetches, queues the
//            returned instructions with their PCs, and discards in-flight
//            responses when a redirect occurs.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_buffer #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter int unsigned       MAX_OUT  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'hbfc00000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         redirect_valid,
    input  logic [ADDR_W-1:0]            redirect_pc,
    output logic                         inst_req,
    output logic [ADDR_W-1:0]            inst_addr,
    input  logic                         inst_addr_ok,
    input  logic                         inst_data_ok,
    input  logic [DATA_W-1:0]            inst_rdata,
    input  logic                         ds_allowin,
    output logic                         fs_to_ds_valid,
    output logic [DATA_W-1:0]            fs_to_ds_inst,
    output logic [ADDR_W-1:0]            fs_to_ds_pc,
    output logic [$clog2(DEPTH+1)-1:0]   fb_count
);

    localparam int unsigned c_CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned c_OUT_W = $clog2(MAX_OUT + 1);
    localparam int unsigned c_PTR_W = $clog2(DEPTH);
    localparam int unsigned c_PQ_W  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    localparam logic [c_OUT_W-1:0] c_MAX_OUT = c_OUT_W'(MAX_OUT);
    localparam logic [c_PQ_W-1:0]  c_PQ_LAST = c_PQ_W'(MAX_OUT - 1);
    localparam logic [c_CNT_W:0]   c_DEPTH   = (c_CNT_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0]  c_PC_STEP = ADDR_W'(4);

    logic [ADDR_W-1:0]  r_fetch_pc;
    logic [c_OUT_W-1:0] r_out_cnt;
    logic [c_OUT_W-1:0] r_cancel_cnt;

    logic [ADDR_W-1:0]  r_pq [MAX_OUT];
    logic [c_PQ_W-1:0]  r_pq_wr;
    logic [c_PQ_W-1:0]  r_pq_rd;

    logic [ADDR_W-1:0]  r_fifo_pc   [DEPTH];
    logic [DATA_W-1:0]  r_fifo_inst [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic [c_OUT_W-1:0] w_live;
    logic [c_CNT_W:0]   w_occ;
    logic               w_req;
    logic               w_valid;
    logic               w_accept;
    logic               w_keep;
    logic               w_drop;
    logic               w_pop;

    // Cancelled responses still occupy the bus but never reach the FIFO,
    // so only live requests reserve FIFO space.
    assign w_live   = r_out_cnt - r_cancel_cnt;
    assign w_occ    = {1'b0, r_count} + (c_CNT_W + 1)'(w_live);
    assign w_req    = !reset && !redirect_valid && (r_out_cnt < c_MAX_OUT) && (w_occ < c_DEPTH);
    assign w_valid  = !reset && !redirect_valid && (r_count != '0);
    assign w_accept = w_req && inst_addr_ok;
    assign w_drop   = inst_data_ok && (r_cancel_cnt != '0);
    assign w_keep   = !reset && !redirect_valid && inst_data_ok && (r_cancel_cnt == '0);
    assign w_pop    = w_valid && ds_allowin;

    assign inst_req       = w_req;
    assign inst_addr      = r_fetch_pc;
    assign fs_to_ds_valid = w_valid;
    assign fs_to_ds_pc    = r_fifo_pc[r_rd_ptr];
    assign fs_to_ds_inst  = r_fifo_inst[r_rd_ptr];
    assign fb_count       = r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc   <= RESET_PC;
            r_out_cnt    <= '0;
            r_cancel_cnt <= '0;
            r_pq_wr      <= '0;
            r_pq_rd      <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
        end else if (redirect_valid) begin
            // Everything still on the bus after this edge belongs to the
            // old stream and must be swallowed when it returns.
            r_fetch_pc   <= redirect_pc;
            r_out_cnt    <= r_out_cnt - c_OUT_W'(inst_data_ok);
            r_cancel_cnt <= r_out_cnt - c_OUT_W'(inst_data_ok);
            r_pq_wr      <= '0;
            r_pq_rd      <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
        end else begin
            r_out_cnt <= r_out_cnt + c_OUT_W'(w_accept) - c_OUT_W'(inst_data_ok);
            if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + c_PC_STEP;
                r_pq_wr    <= (r_pq_wr == c_PQ_LAST) ? '0 : r_pq_wr + 1'b1;
            end
            if (w_drop) begin
                r_cancel_cnt <= r_cancel_cnt - 1'b1;
            end
            if (w_keep) begin
                r_pq_rd  <= (r_pq_rd == c_PQ_LAST) ? '0 : r_pq_rd + 1'b1;
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + c_CNT_W'(w_keep) - c_CNT_W'(w_pop);
        end
    end

    // Storage arrays carry no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pq[r_pq_wr] <= r_fetch_pc;
        end
        if (w_keep) begin
            r_fifo_pc[r_wr_ptr]   <= r_pq[r_pq_rd];
            r_fifo_inst[r_wr_ptr] <= inst_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch_buffer
// Brief    : Randomized bench for inst_fetch_buffer against a queue-based
//            reference model with an in-order bus responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_buffer;

    localparam int unsigned c_DEPTH   = 4;
    localparam int unsigned c_MAX_OUT = 2;
    localparam logic [31:0] c_RST_PC  = 32'hbfc00000;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        ds_allowin;
    logic        fs_to_ds_valid;
    logic [31:0] fs_to_ds_inst;
    logic [31:0] fs_to_ds_pc;
    logic [2:0]  fb_count;

    inst_fetch_buffer #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .DEPTH    (c_DEPTH),
        .MAX_OUT  (c_MAX_OUT),
        .RESET_PC (c_RST_PC)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_req       (inst_req),
        .inst_addr      (inst_addr),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_rdata     (inst_rdata),
        .ds_allowin     (ds_allowin),
        .fs_to_ds_valid (fs_to_ds_valid),
        .fs_to_ds_inst  (fs_to_ds_inst),
        .fs_to_ds_pc    (fs_to_ds_pc),
        .fb_count       (fb_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        bit          canc;
        int          ready;
    } req_t;

    req_t        infl[$];
    logic [63:0] fifo[$];
    logic [31:0] m_pc;
    int          cyc;

    int p_aok, p_allow, p_redir, p_rst, max_dly;
    int n_vec, n_err;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hdeadbeef;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic cycle(input bit frc_rst, input bit frc_redir, input logic [31:0] rpc);
        int   live;
        bit   e_req, e_valid;
        req_t h;
        @(negedge clk);
        reset          = frc_rst || ($urandom_range(0, 999) < p_rst);
        redirect_valid = frc_redir || ($urandom_range(0, 99) < p_redir);
        redirect_pc    = frc_redir ? rpc : ($urandom() & 32'hffff_fffc);
        inst_addr_ok   = $urandom_range(0, 99) < p_aok;
        ds_allowin     = $urandom_range(0, 99) < p_allow;
        inst_data_ok   = (infl.size() > 0) && (cyc >= infl[0].ready);
        inst_rdata     = inst_data_ok ? mem_word(infl[0].addr) : $urandom();
        #1;
        live = 0;
        foreach (infl[i]) if (!infl[i].canc) live++;
        e_req   = !reset && !redirect_valid && (infl.size() < c_MAX_OUT) &&
                  (fifo.size() + live < c_DEPTH);
        e_valid = !reset && !redirect_valid && (fifo.size() != 0);
        chk("inst_req", 64'(inst_req), 64'(e_req));
        chk("inst_addr", 64'(inst_addr), 64'(m_pc));
        chk("valid", 64'(fs_to_ds_valid), 64'(e_valid));
        chk("fb_count", 64'(fb_count), 64'(fifo.size()));
        if (e_valid && fs_to_ds_valid)
            chk("head", {fs_to_ds_pc, fs_to_ds_inst}, fifo[0]);
        @(posedge clk);
        if (reset) begin
            infl.delete();
            fifo.delete();
            m_pc = c_RST_PC;
        end else if (redirect_valid) begin
            if (inst_data_ok) void'(infl.pop_front());
            foreach (infl[i]) infl[i].canc = 1'b1;
            fifo.delete();
            m_pc = redirect_pc;
        end else begin
            if (e_valid && ds_allowin) void'(fifo.pop_front());
            if (inst_data_ok) begin
                h = infl.pop_front();
                if (!h.canc) fifo.push_back({h.addr, mem_word(h.addr)});
            end
            if (e_req && inst_addr_ok) begin
                infl.push_back('{addr: m_pc, canc: 1'b0,
                                 ready: cyc + 1 + $urandom_range(0, max_dly)});
                m_pc = m_pc + 32'd4;
            end
        end
        cyc++;
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0;
        m_pc = c_RST_PC;
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0; ds_allowin = 1'b0;
        p_aok = 100; p_allow = 100; p_redir = 0; p_rst = 0; max_dly = 0;
        repeat (2) @(posedge clk);
        // Reset state, then streaming at full rate.
        cycle(1'b1, 1'b0, '0);
        repeat (30) cycle(1'b0, 1'b0, '0);
        // Decode stalled: FIFO fills and requests stop.
        p_allow = 0;
        repeat (10) cycle(1'b0, 1'b0, '0);
        p_allow = 100;
        repeat (10) cycle(1'b0, 1'b0, '0);
        // Redirect with both requests outstanding.
        max_dly = 4;
        repeat (3) cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 32'h0000_1000);
        repeat (20) cycle(1'b0, 1'b0, '0);
        // Reset with traffic in flight.
        p_allow = 0; max_dly = 1;
        repeat (4) cycle(1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, '0);
        p_allow = 100; max_dly = 0;
        repeat (10) cycle(1'b0, 1'b0, '0);
        // Random traffic with redirects and occasional resets.
        p_aok = 60; p_allow = 70; p_redir = 5; p_rst = 5; max_dly = 5;
        repeat (3000) cycle(1'b0, 1'b0, '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
